// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between dcache, icache, the
// arbiter and the single RAM port.
//   slave  - arbiter view: takes cache requests and RAM status/data, drives
//            wait/load back to the caches and enables/addr/data to RAM.
//   master - environment view (caches + RAM): the mirror image.
interface mem_arbiter_if;
  // dcache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // icache side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: puts dcache and icache requests onto one RAM port, one access
// at a time. The request is latched at grant and held on the RAM port until
// RAM reports ACCESS. dcache has priority; with MEM_ARB_FAIR_EN defined the
// icache is forced ahead after STARVE_LIMIT consecutive dcache grants made
// while it was waiting.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (cache requests, wait/load, RAM port)
// Optional build macro: MEM_ARB_FAIR_EN (icache starvation guard).
module mem_arbiter
`ifdef MEM_ARB_FAIR_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DSRV, ISRV} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;

  state_t      state_q, state_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;

  logic dreq, ireq, done, force_i;

  always_comb begin
    dreq = bus.dREN | bus.dWEN;
    ireq = bus.iREN;
    done = (bus.ramstate == RAM_ACCESS);
  end

`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only reaches the limit while iREN is pending, and at the limit
  // the next grant (with iREN high) goes to the icache, so it cannot wrap.
  always_comb force_i = (cnt_q == CW'(STARVE_LIMIT)) && ireq;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (state_d == DSRV)      cnt_d = ireq ? cnt_q + 1'b1 : '0;
      else if (state_d == ISRV) cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  always_comb force_i = 1'b0;
`endif

  // State register, RAM-port registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

  // Next state. Dropping every request line of the granted side aborts the
  // access, and that takes precedence over a same-cycle ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dreq && !force_i) state_d = DSRV;
        else if (ireq)        state_d = ISRV;
      end
      DSRV:    if (!dreq || done) state_d = IDLE;
      ISRV:    if (!ireq || done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request at grant; clear the enables on the way back to IDLE.
  // Address/data just hold between accesses.
  always_comb begin
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    store_d = store_q;
    if (state_q == IDLE) begin
      ren_d = 1'b0;
      wen_d = 1'b0;
      if (state_d == DSRV) begin
        wen_d   = bus.dWEN;
        ren_d   = !bus.dWEN;  // write wins when both are raised
        addr_d  = bus.daddr;
        store_d = bus.dstore;
      end else if (state_d == ISRV) begin
        ren_d  = 1'b1;
        addr_d = bus.iaddr;
      end
    end else if (state_d == IDLE) begin
      ren_d = 1'b0;
      wen_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    bus.ramREN   = ren_q;
    bus.ramWEN   = wen_q;
    bus.ramaddr  = addr_q;
    bus.ramstore = store_q;
    bus.dwait    = !((state_q == DSRV) && dreq && done);
    bus.iwait    = !((state_q == ISRV) && ireq && done);
    bus.dload    = bus.ramload;
    bus.iload    = bus.ramload;
  end

endmodule
